// File: rtl/idma_mp_cpl_join.sv
// idma_mp_cpl_join: joins per-back-end responses of the multi-port iDMA into
// one in-order upstream response per issued request.
// Optional build macro: IDMA_MP_CPL_JOIN_OUT_REG_EN adds a spill register on
// the upstream response port (one extra cycle of latency, full throughput).
`default_nettype none

module idma_mp_cpl_join #(
    parameter int unsigned NumBEs         = 1,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         idma_rsp_t     = logic
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 issue_valid_i,
    output logic                                 issue_ready_o,
    input  logic [NumBEs-1:0]                    issue_mask_i,
    input  idma_rsp_t [NumBEs-1:0]               idma_rsp_i,
    input  logic [NumBEs-1:0]                    idma_rsp_valid_i,
    output logic [NumBEs-1:0]                    idma_rsp_ready_o,
    output idma_rsp_t                            idma_rsp_o,
    output logic                                 idma_rsp_valid_o,
    input  logic                                 idma_rsp_ready_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    logic [NumBEs-1:0] mask_mem_q [MaxOutstanding];
    logic [PtrW-1:0]   mask_wr_q;
    logic [PtrW-1:0]   mask_rd_q;
    logic [CntW-1:0]   mask_cnt_q;
    logic              mask_push;
    logic              mask_empty;
    logic [NumBEs-1:0] head_mask;

    idma_rsp_t [NumBEs-1:0] rsp_head;
    logic [NumBEs-1:0]      rsp_empty;
    logic [NumBEs-1:0]      rsp_push;
    logic [NumBEs-1:0]      rsp_pop;

    logic      join_valid;
    logic      join_ready;
    logic      join_pop;
    idma_rsp_t join_data;

    assign issue_ready_o = (mask_cnt_q != CntFull);
    assign mask_push     = issue_valid_i && issue_ready_o;
    assign mask_empty    = (mask_cnt_q == '0);
    assign head_mask     = mask_mem_q[mask_rd_q];
    assign join_pop      = join_valid && join_ready;
    assign rsp_pop       = join_pop ? head_mask : '0;

    // Mask FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (mask_push) begin
            mask_mem_q[mask_wr_q] <= issue_mask_i;
        end
    end

    // Mask FIFO pointers and fill level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mask_wr_q  <= '0;
            mask_rd_q  <= '0;
            mask_cnt_q <= '0;
        end else begin
            if (mask_push) mask_wr_q <= ptr_inc(mask_wr_q);
            if (join_pop)  mask_rd_q <= ptr_inc(mask_rd_q);
            case ({mask_push, join_pop})
                2'b10:   mask_cnt_q <= mask_cnt_q + CntW'(1);
                2'b01:   mask_cnt_q <= mask_cnt_q - CntW'(1);
                default: mask_cnt_q <= mask_cnt_q;
            endcase
        end
    end

    for (genvar g = 0; g < NumBEs; g++) begin : gen_be
        idma_rsp_t       mem_q [MaxOutstanding];
        logic [PtrW-1:0] wr_q;
        logic [PtrW-1:0] rd_q;
        logic [CntW-1:0] cnt_q;

        assign idma_rsp_ready_o[g] = (cnt_q != CntFull);
        assign rsp_push[g]         = idma_rsp_valid_i[g] && idma_rsp_ready_o[g];
        assign rsp_empty[g]        = (cnt_q == '0);
        assign rsp_head[g]         = mem_q[rd_q];

        // Per-back-end response storage.
        always_ff @(posedge clk_i) begin
            if (rsp_push[g]) begin
                mem_q[wr_q] <= idma_rsp_i[g];
            end
        end

        // Per-back-end response FIFO pointers and fill level.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (rsp_push[g]) wr_q <= ptr_inc(wr_q);
                if (rsp_pop[g])  rd_q <= ptr_inc(rd_q);
                case ({rsp_push[g], rsp_pop[g]})
                    2'b10:   cnt_q <= cnt_q + CntW'(1);
                    2'b01:   cnt_q <= cnt_q - CntW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // Head completes when every participating back-end has a buffered response.
    always_comb begin
        logic all_present;
        all_present = 1'b1;
        join_data   = '0;
        for (int unsigned i = 0; i < NumBEs; i++) begin
            if (head_mask[i] && rsp_empty[i]) all_present = 1'b0;
        end
        join_valid = !mask_empty && all_present;
        if (join_valid) begin
            for (int unsigned i = 0; i < NumBEs; i++) begin
                if (head_mask[i]) join_data = idma_rsp_t'(join_data | rsp_head[i]);
            end
        end
    end

`ifdef IDMA_MP_CPL_JOIN_OUT_REG_EN
    logic      a_full_q;
    logic      b_full_q;
    logic      a_full_d;
    logic      b_full_d;
    logic      a_fill;
    logic      a_drain;
    logic      b_fill;
    logic      b_drain;
    logic      out_valid_q;
    idma_rsp_t a_data_q;
    idma_rsp_t b_data_q;
    logic [CntW-1:0] out_cnt_q;
    logic      out_retire;

    assign join_ready = !a_full_q || !b_full_q;
    assign a_fill     = join_valid && join_ready;
    assign a_drain    = a_full_q && !b_full_q;
    assign b_fill     = a_drain && !idma_rsp_ready_i;
    assign b_drain    = b_full_q && idma_rsp_ready_i;
    assign a_full_d   = a_fill || (a_full_q && !a_drain);
    assign b_full_d   = b_fill || (b_full_q && !b_drain);

    assign idma_rsp_valid_o = out_valid_q;
    assign idma_rsp_o       = b_full_q ? b_data_q : a_data_q;
    assign out_retire       = idma_rsp_valid_o && idma_rsp_ready_i;
    assign outstanding_o    = out_cnt_q;

    // Spill register: slot b holds the older entry while upstream stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_full_q    <= 1'b0;
            b_full_q    <= 1'b0;
            out_valid_q <= 1'b0;
            a_data_q    <= '0;
            b_data_q    <= '0;
        end else begin
            a_full_q    <= a_full_d;
            b_full_q    <= b_full_d;
            out_valid_q <= a_full_d || b_full_d;
            if (a_fill) a_data_q <= join_data;
            if (b_fill) b_data_q <= a_data_q;
        end
    end

    // Requests stay counted until they leave the spill register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt_q <= '0;
        end else begin
            case ({mask_push, out_retire})
                2'b10:   out_cnt_q <= out_cnt_q + CntW'(1);
                2'b01:   out_cnt_q <= out_cnt_q - CntW'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end
`else
    assign join_ready       = idma_rsp_ready_i;
    assign idma_rsp_valid_o = join_valid;
    assign idma_rsp_o       = join_data;
    assign outstanding_o    = mask_cnt_q;
`endif

`ifndef SYNTHESIS
    // Issue while the mask FIFO is full is illegal.
    a_issue_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        issue_valid_i |-> issue_ready_o)
        else $error("idma_mp_cpl_join: issue while full");

    for (genvar g = 0; g < NumBEs; g++) begin : gen_chk
        logic [CntW-1:0] pend_q;

        // Requests naming this back-end minus responses already received from it.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                pend_q <= '0;
            end else begin
                pend_q <= pend_q + CntW'(mask_push && issue_mask_i[g]) - CntW'(rsp_push[g]);
            end
        end

        // A response needs an unretired request that includes this back-end.
        a_rsp_orphan : assert property (@(posedge clk_i) disable iff (!rst_ni)
            rsp_push[g] |-> (pend_q != '0))
            else $error("idma_mp_cpl_join: unexpected response from back-end %0d", g);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_idma_mp_cpl_join.sv
// Testbench for idma_mp_cpl_join (4 back-ends, 4 outstanding, 8-bit responses).
// Expected joined responses are queued at issue time and popped by a monitor.
`timescale 1ns/1ps

module tb_idma_mp_cpl_join;

    typedef logic [7:0] rsp_t;
    localparam int unsigned NB = 4;
    localparam int unsigned MO = 4;
`ifdef IDMA_MP_CPL_JOIN_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk;
    logic            rst_n;
    logic            issue_valid;
    logic            issue_ready;
    logic [NB-1:0]   issue_mask;
    rsp_t [NB-1:0]   be_rsp;
    logic [NB-1:0]   be_valid;
    logic [NB-1:0]   be_ready;
    rsp_t            rsp_out;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2:0]      outstanding;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    idma_mp_cpl_join #(
        .NumBEs         (NB),
        .MaxOutstanding (MO),
        .idma_rsp_t     (rsp_t)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .issue_valid_i    (issue_valid),
        .issue_ready_o    (issue_ready),
        .issue_mask_i     (issue_mask),
        .idma_rsp_i       (be_rsp),
        .idma_rsp_valid_i (be_valid),
        .idma_rsp_ready_o (be_ready),
        .idma_rsp_o       (rsp_out),
        .idma_rsp_valid_o (rsp_valid),
        .idma_rsp_ready_i (rsp_ready),
        .outstanding_o    (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every upstream handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got rsp=%h, required no response", rsp_out);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if (rsp_out !== e) begin
                    errors++;
                    $display("FAIL scoreboard_data: got rsp=%h, required %h", rsp_out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input logic [NB-1:0] mask, input rsp_t exp);
        issue_valid = 1'b1;
        issue_mask  = mask;
        exp_q.push_back(exp);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic drive_be(input int i, input rsp_t d);
        be_valid[i] = 1'b1;
        be_rsp[i]   = d;
        tick();
        be_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((rsp_valid === 1'b1 || outstanding !== 3'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b0 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL %s_drain: valid=%b outstanding=%0d, required valid=0 outstanding=0",
                     name, rsp_valid, outstanding);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks += 5;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b, required 1", issue_ready); end
        if (be_ready !== 4'hF) begin errors++; $display("FAIL reset_be_ready: got %b, required 1111", be_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", rsp_valid); end
        if (rsp_out !== 8'h00) begin errors++; $display("FAIL reset_rsp: got %h, required 00", rsp_out); end
        if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d, required 0", outstanding); end
        tick();
    endtask

    task automatic test_basic_join();
        issue_one(4'b0101, 8'h03);
        @(negedge clk);
        checks += 2;
        if (outstanding !== 3'd1) begin errors++; $display("FAIL basic_outstanding_1: got %0d, required 1", outstanding); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b, required 0", rsp_valid); end
        tick();
        drive_be(0, 8'h01);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_partial: got valid=%b, required 0", rsp_valid); end
        tick();
        drive_be(2, 8'h02);
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got valid=%b, required 0", rsp_valid); end
            tick();
        end
        @(negedge clk);
        checks += 3;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, required 1", rsp_valid); end
        if (rsp_out !== 8'h03) begin errors++; $display("FAIL basic_data: got %h, required 03", rsp_out); end
        if (outstanding !== 3'd1) begin errors++; $display("FAIL basic_outstanding_pre: got %0d, required 1", outstanding); end
        tick();
        @(negedge clk);
        checks += 2;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b, required 0", rsp_valid); end
        if (outstanding !== 3'd0) begin errors++; $display("FAIL basic_outstanding_0: got %0d, required 0", outstanding); end
        tick();
    endtask

    task automatic test_out_of_order();
        issue_one(4'b0011, 8'h14);
        issue_one(4'b0010, 8'h20);
        drive_be(1, 8'h10);
        drive_be(1, 8'h20);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ooo_wait_%0d: got valid=%b, required 0", k, rsp_valid); end
            tick();
        end
        drive_be(0, 8'h04);
        for (int k = 1; k < LAT; k++) tick();
        @(negedge clk);
        checks += 2;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ooo_first_valid: got %b, required 1", rsp_valid); end
        if (rsp_out !== 8'h14) begin errors++; $display("FAIL ooo_first_data: got %h, required 14", rsp_out); end
        tick();
        @(negedge clk);
        checks += 2;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ooo_second_valid: got %b, required 1", rsp_valid); end
        if (rsp_out !== 8'h20) begin errors++; $display("FAIL ooo_second_data: got %h, required 20", rsp_out); end
        tick();
        wait_idle(10, "ooo");
    endtask

    task automatic test_zero_mask();
        issue_one(4'b0000, 8'h00);
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL zero_latency: got valid=%b, required 0", rsp_valid); end
            tick();
        end
        @(negedge clk);
        checks += 2;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b, required 1", rsp_valid); end
        if (rsp_out !== 8'h00) begin errors++; $display("FAIL zero_data: got %h, required 00", rsp_out); end
        tick();
        wait_idle(10, "zero");
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) issue_one(4'b0001, rsp_t'(8'h41 + k));
        @(negedge clk);
        checks += 2;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, required 0", issue_ready); end
        if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding: got %0d, required 4", outstanding); end
        tick();
        drive_be(0, 8'h41);
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready_before_retire: got %b, required 0", issue_ready); end
        tick();
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_retire: got %b, required 1", issue_ready); end
        tick();
        issue_one(4'b0001, 8'h45);
        for (int k = 0; k < 4; k++) drive_be(0, rsp_t'(8'h42 + k));
        wait_idle(20, "full");
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) issue_one(4'b0001, rsp_t'(8'h51 + k));
        for (int k = 0; k < 4; k++) drive_be(0, rsp_t'(8'h51 + k));
        @(negedge clk);
        checks++;
        if (be_ready !== ((LAT == 1) ? 4'b1110 : 4'b1111)) begin
            errors++;
            $display("FAIL stall_be_ready: got %b, required %b", be_ready, (LAT == 1) ? 4'b1110 : 4'b1111);
        end
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %b, required 1", k, rsp_valid); end
            if (rsp_out !== 8'h51) begin errors++; $display("FAIL stall_data_%0d: got %h, required 51", k, rsp_out); end
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        wait_idle(20, "stall");
    endtask

    task automatic test_reset_mid();
        issue_one(4'b0011, 8'h00);
        issue_one(4'b0011, 8'h00);
        issue_one(4'b0011, 8'h00);
        drive_be(0, 8'h01);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks += 5;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL midrst_issue_ready: got %b, required 1", issue_ready); end
        if (be_ready !== 4'hF) begin errors++; $display("FAIL midrst_be_ready: got %b, required 1111", be_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", rsp_valid); end
        if (rsp_out !== 8'h00) begin errors++; $display("FAIL midrst_rsp: got %h, required 00", rsp_out); end
        if (outstanding !== 3'd0) begin errors++; $display("FAIL midrst_outstanding: got %0d, required 0", outstanding); end
        tick();
        issue_one(4'b0100, 8'h77);
        drive_be(2, 8'h77);
        wait_idle(10, "midrst");
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_mask  = '0;
        be_rsp      = '0;
        be_valid    = '0;
        rsp_ready   = 1'b1;

        test_reset();
        test_basic_join();
        test_out_of_order();
        test_zero_mask();
        test_full();
        test_stall();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending responses, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
